// File: rtl/llc_set_read.sv
// ============================================================================
//  Module      : llc_set_read
//  Description : LLC set-read stage. Fetches every way of one set (tag,
//                state, hprot, line, owner, sharers, dirty bit) and the set's
//                evict way from local memory into the set buffers. It then
//                registers the tag hit / hit way / first empty way for the
//                process stage and holds the buffers stable until the
//                process stage acknowledges them.
//  Ports       : clk, rst (async, active-high)
//                req_valid/req_ready/req_set/req_tag   request handshake
//                rd_en/rd_set, rd_data_*               local-memory read
//                wr_en/wr_set/wr_way/wr_data_*         update-stage writes
//                bufs_valid/bufs_ack, *_buf            set buffers
//                tag_hit/hit_way/empty_way/empty_way_found  lookup results
//  Parameters  : RD_LAT (1..4) local-memory read latency in cycles
//  Option      : define LLC_RD_BYPASS_EN to forward same-set update-stage
//                writes into the buffers while a read is in WAIT or HOLD.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef LLC_WAYS
`define LLC_WAYS 16
`endif
`ifndef INVALID
`define INVALID 3'd0
`endif
`ifndef VALID
`define VALID 3'd1
`endif

package llc_set_read_pkg;
    typedef logic [7:0]  llc_set_t;
    typedef logic [15:0] llc_tag_t;
    typedef logic [3:0]  llc_way_t;
    typedef logic [2:0]  llc_state_t;
    typedef logic        llc_hprot_t;
    typedef logic [63:0] line_t;
    typedef logic [3:0]  owner_t;
    typedef logic [15:0] sharers_t;
endpackage

module llc_set_read
    import llc_set_read_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    // request side
    input  logic       req_valid,
    output logic       req_ready,
    input  llc_set_t   req_set,
    input  llc_tag_t   req_tag,
    // local-memory read port
    output logic       rd_en,
    output llc_set_t   rd_set,
    input  llc_tag_t   rd_data_tag       [`LLC_WAYS],
    input  llc_state_t rd_data_state     [`LLC_WAYS],
    input  llc_hprot_t rd_data_hprot     [`LLC_WAYS],
    input  line_t      rd_data_line      [`LLC_WAYS],
    input  owner_t     rd_data_owner     [`LLC_WAYS],
    input  sharers_t   rd_data_sharers   [`LLC_WAYS],
    input  logic       rd_data_dirty_bit [`LLC_WAYS],
    input  llc_way_t   rd_data_evict_way,
    // update-stage write snoop
    input  logic       wr_en,
    input  llc_set_t   wr_set,
    input  llc_way_t   wr_way,
    input  llc_tag_t   wr_data_tag,
    input  llc_state_t wr_data_state,
    input  llc_hprot_t wr_data_hprot,
    input  line_t      wr_data_line,
    input  owner_t     wr_data_owner,
    input  sharers_t   wr_data_sharers,
    input  logic       wr_data_dirty_bit,
    input  llc_way_t   wr_data_evict_way,
    // set buffers towards the process stage
    output logic       bufs_valid,
    input  logic       bufs_ack,
    output llc_tag_t   tags_buf          [`LLC_WAYS],
    output llc_state_t states_buf        [`LLC_WAYS],
    output llc_hprot_t hprots_buf        [`LLC_WAYS],
    output line_t      lines_buf         [`LLC_WAYS],
    output owner_t     owners_buf        [`LLC_WAYS],
    output sharers_t   sharers_buf       [`LLC_WAYS],
    output logic       dirty_bits_buf    [`LLC_WAYS],
    output llc_way_t   evict_way_buf,
    output logic       tag_hit,
    output llc_way_t   hit_way,
    output llc_way_t   empty_way,
    output logic       empty_way_found
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    localparam logic [1:0] c_LAT_LOAD = 2'(RD_LAT - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [1:0]           r_cnt;
    llc_set_t             r_set;
    llc_tag_t             r_tag;
    // ways (and the evict way) already overwritten by a forwarded write
    // during WAIT; the later memory capture must not clobber them
    logic [`LLC_WAYS-1:0] r_byp_mask;
    logic                 r_byp_evict;

    logic                 w_capture;
    logic                 w_bypass;
    logic                 w_load;
    logic                 w_ack;

    llc_tag_t             w_nxt_tag     [`LLC_WAYS];
    llc_state_t           w_nxt_state   [`LLC_WAYS];
    llc_hprot_t           w_nxt_hprot   [`LLC_WAYS];
    line_t                w_nxt_line    [`LLC_WAYS];
    owner_t               w_nxt_owner   [`LLC_WAYS];
    sharers_t             w_nxt_sharers [`LLC_WAYS];
    logic                 w_nxt_dirty   [`LLC_WAYS];
    llc_way_t             w_nxt_evict;

    logic                 w_hit;
    llc_way_t             w_hit_way;
    logic                 w_empty_found;
    llc_way_t             w_empty_way;

    assign w_capture = (r_state == c_WAIT) && (r_cnt == 2'd0);
    assign w_ack     = (r_state == c_HOLD) && bufs_valid && bufs_ack;

`ifdef LLC_RD_BYPASS_EN
    assign w_bypass = wr_en && (wr_set == r_set) &&
                      ((r_state == c_WAIT) || (r_state == c_HOLD));
`else
    // Scheduler never writes the set under read, so the snoop port is dead.
    logic w_unused_wr;
    always_comb begin
        w_unused_wr = ^{wr_en, wr_set, wr_way, wr_data_tag, wr_data_state,
                        wr_data_hprot, wr_data_line, wr_data_owner,
                        wr_data_sharers, wr_data_dirty_bit, wr_data_evict_way};
    end
    assign w_bypass = 1'b0;
`endif

    assign w_load = w_capture || w_bypass;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (req_valid) w_state_nxt = c_ISSUE;
            c_ISSUE: w_state_nxt = c_WAIT;
            c_WAIT:  if (r_cnt == 2'd0) w_state_nxt = c_HOLD;
            c_HOLD:  if (bufs_valid && bufs_ack) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = 1'b0;
        rd_en     = 1'b0;
        case (r_state)
            c_IDLE:  req_ready = 1'b1;
            c_ISSUE: rd_en     = 1'b1;
            default: ;
        endcase
    end

    assign rd_set = r_set;

    // ------------------------------------------------------------------
    // Request latch, latency counter, bypass tracking, bufs_valid
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_set       <= '0;
            r_tag       <= '0;
            r_cnt       <= 2'd0;
            r_byp_mask  <= '0;
            r_byp_evict <= 1'b0;
            bufs_valid  <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && req_valid) begin
                r_set <= req_set;
                r_tag <= req_tag;
            end
            if (r_state == c_ISSUE) begin
                r_cnt       <= c_LAT_LOAD;
                r_byp_mask  <= '0;
                r_byp_evict <= 1'b0;
            end else if ((r_state == c_WAIT) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_bypass) begin
                r_byp_mask[wr_way] <= 1'b1;
                r_byp_evict        <= 1'b1;
            end
            // valid one cycle after capture so hit/empty are already settled
            if (w_ack) begin
                bufs_valid <= 1'b0;
            end else if ((r_state == c_HOLD) && !bufs_valid) begin
                bufs_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next buffer contents: memory capture, then forwarded write on top
    // (write data wins when both land in the same cycle)
    // ------------------------------------------------------------------
    always_comb begin
        for (int w = 0; w < `LLC_WAYS; w++) begin
            w_nxt_tag[w]     = tags_buf[w];
            w_nxt_state[w]   = states_buf[w];
            w_nxt_hprot[w]   = hprots_buf[w];
            w_nxt_line[w]    = lines_buf[w];
            w_nxt_owner[w]   = owners_buf[w];
            w_nxt_sharers[w] = sharers_buf[w];
            w_nxt_dirty[w]   = dirty_bits_buf[w];
            if (w_capture && !r_byp_mask[w]) begin
                w_nxt_tag[w]     = rd_data_tag[w];
                w_nxt_state[w]   = rd_data_state[w];
                w_nxt_hprot[w]   = rd_data_hprot[w];
                w_nxt_line[w]    = rd_data_line[w];
                w_nxt_owner[w]   = rd_data_owner[w];
                w_nxt_sharers[w] = rd_data_sharers[w];
                w_nxt_dirty[w]   = rd_data_dirty_bit[w];
            end
        end
        w_nxt_evict = evict_way_buf;
        if (w_capture && !r_byp_evict) begin
            w_nxt_evict = rd_data_evict_way;
        end
`ifdef LLC_RD_BYPASS_EN
        if (w_bypass) begin
            w_nxt_tag[wr_way]     = wr_data_tag;
            w_nxt_state[wr_way]   = wr_data_state;
            w_nxt_hprot[wr_way]   = wr_data_hprot;
            w_nxt_line[wr_way]    = wr_data_line;
            w_nxt_owner[wr_way]   = wr_data_owner;
            w_nxt_sharers[wr_way] = wr_data_sharers;
            w_nxt_dirty[wr_way]   = wr_data_dirty_bit;
            w_nxt_evict           = wr_data_evict_way;
        end
`endif
    end

    // Lookup on the values about to be stored; lowest way index wins.
    always_comb begin
        w_hit         = 1'b0;
        w_hit_way     = '0;
        w_empty_found = 1'b0;
        w_empty_way   = '0;
        for (int w = 0; w < `LLC_WAYS; w++) begin
            if (!w_hit && (w_nxt_state[w] != `INVALID) && (w_nxt_tag[w] == r_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = llc_way_t'(w);
            end
            if (!w_empty_found && (w_nxt_state[w] == `INVALID)) begin
                w_empty_found = 1'b1;
                w_empty_way   = llc_way_t'(w);
            end
        end
    end

    // ------------------------------------------------------------------
    // Set buffers and registered lookup results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < `LLC_WAYS; w++) begin
                tags_buf[w]       <= '0;
                states_buf[w]     <= '0;
                hprots_buf[w]     <= '0;
                lines_buf[w]      <= '0;
                owners_buf[w]     <= '0;
                sharers_buf[w]    <= '0;
                dirty_bits_buf[w] <= 1'b0;
            end
            evict_way_buf   <= '0;
            tag_hit         <= 1'b0;
            hit_way         <= '0;
            empty_way       <= '0;
            empty_way_found <= 1'b0;
        end else if (w_load) begin
            for (int w = 0; w < `LLC_WAYS; w++) begin
                tags_buf[w]       <= w_nxt_tag[w];
                states_buf[w]     <= w_nxt_state[w];
                hprots_buf[w]     <= w_nxt_hprot[w];
                lines_buf[w]      <= w_nxt_line[w];
                owners_buf[w]     <= w_nxt_owner[w];
                sharers_buf[w]    <= w_nxt_sharers[w];
                dirty_bits_buf[w] <= w_nxt_dirty[w];
            end
            evict_way_buf   <= w_nxt_evict;
            tag_hit         <= w_hit;
            hit_way         <= w_hit_way;
            empty_way       <= w_empty_way;
            empty_way_found <= w_empty_found;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_llc_set_read.sv
// ============================================================================
//  Module      : tb_llc_set_read
//  Description : Scoreboard bench for llc_set_read (RD_LAT = 3). Stimulus
//                pushes hand-computed expectations; a monitor pops them when
//                bufs_valid rises and re-checks them every held cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef LLC_WAYS
`define LLC_WAYS 16
`endif
`ifndef INVALID
`define INVALID 3'd0
`endif
`ifndef VALID
`define VALID 3'd1
`endif

module tb_llc_set_read;
    import llc_set_read_pkg::*;

    localparam int RD_LAT = 3;
    localparam int NW     = `LLC_WAYS;

    typedef struct {
        int         cyc;
        logic       hit;
        llc_way_t   hw;
        logic       ef;
        llc_way_t   ew;
        llc_way_t   ev;
        llc_way_t   cw;
        llc_tag_t   ctag;
        llc_state_t cst;
        line_t      cline;
        owner_t     cown;
        sharers_t   csh;
        logic       cdirty;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready;
    llc_set_t req_set, rd_set, wr_set;
    llc_tag_t req_tag;
    logic rd_en;
    llc_tag_t   rd_data_tag [NW];
    llc_state_t rd_data_state [NW];
    llc_hprot_t rd_data_hprot [NW];
    line_t      rd_data_line [NW];
    owner_t     rd_data_owner [NW];
    sharers_t   rd_data_sharers [NW];
    logic       rd_data_dirty_bit [NW];
    llc_way_t   rd_data_evict_way;
    logic wr_en;
    llc_way_t wr_way;
    llc_tag_t wr_data_tag;
    llc_state_t wr_data_state;
    llc_hprot_t wr_data_hprot;
    line_t wr_data_line;
    owner_t wr_data_owner;
    sharers_t wr_data_sharers;
    logic wr_data_dirty_bit;
    llc_way_t wr_data_evict_way;
    logic bufs_valid, bufs_ack;
    llc_tag_t   tags_buf [NW];
    llc_state_t states_buf [NW];
    llc_hprot_t hprots_buf [NW];
    line_t      lines_buf [NW];
    owner_t     owners_buf [NW];
    sharers_t   sharers_buf [NW];
    logic       dirty_bits_buf [NW];
    llc_way_t evict_way_buf, hit_way, empty_way;
    logic tag_hit, empty_way_found;

    // memory image presented during the read-data window
    llc_tag_t   m_tag [NW];
    llc_state_t m_state [NW];
    llc_way_t   m_evict;
    llc_set_t   m_set;
    logic [3:0] rd_pipe = 4'd0;

    int   cyc = 0;
    int   rd_pulses = 0;
    int   accepts = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ack_delay = 2;
    int   last_ack_edge = -1;
    exp_t exp_q[$];
    exp_t upd_q[$];

    always #5 clk = ~clk;

    llc_set_read #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
        .rd_en(rd_en), .rd_set(rd_set),
        .rd_data_tag(rd_data_tag), .rd_data_state(rd_data_state), .rd_data_hprot(rd_data_hprot),
        .rd_data_line(rd_data_line), .rd_data_owner(rd_data_owner), .rd_data_sharers(rd_data_sharers),
        .rd_data_dirty_bit(rd_data_dirty_bit), .rd_data_evict_way(rd_data_evict_way),
        .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way),
        .wr_data_tag(wr_data_tag), .wr_data_state(wr_data_state), .wr_data_hprot(wr_data_hprot),
        .wr_data_line(wr_data_line), .wr_data_owner(wr_data_owner), .wr_data_sharers(wr_data_sharers),
        .wr_data_dirty_bit(wr_data_dirty_bit), .wr_data_evict_way(wr_data_evict_way),
        .bufs_valid(bufs_valid), .bufs_ack(bufs_ack),
        .tags_buf(tags_buf), .states_buf(states_buf), .hprots_buf(hprots_buf), .lines_buf(lines_buf),
        .owners_buf(owners_buf), .sharers_buf(sharers_buf), .dirty_bits_buf(dirty_bits_buf),
        .evict_way_buf(evict_way_buf), .tag_hit(tag_hit), .hit_way(hit_way),
        .empty_way(empty_way), .empty_way_found(empty_way_found)
    );

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pipe <= {rd_pipe[2:0], rd_en};
        if (rd_en) rd_pulses <= rd_pulses + 1;
    end

    // Memory model: real data only RD_LAT cycles after the rd_en pulse,
    // junk otherwise so an early or late capture is visible.
    always_comb begin
        for (int w = 0; w < NW; w++) begin
            if (rd_pipe[RD_LAT-1]) begin
                rd_data_tag[w]       = m_tag[w];
                rd_data_state[w]     = m_state[w];
                rd_data_hprot[w]     = w[1];
                rd_data_line[w]      = {48'hC0DE_0000_0000, m_set, 8'(w)};
                rd_data_owner[w]     = 4'(w);
                rd_data_sharers[w]   = 16'(1 << w);
                rd_data_dirty_bit[w] = w[0];
            end else begin
                rd_data_tag[w]       = 16'hDEAD;
                rd_data_state[w]     = 3'd7;
                rd_data_hprot[w]     = 1'b1;
                rd_data_line[w]      = '1;
                rd_data_owner[w]     = 4'hE;
                rd_data_sharers[w]   = 16'hFFFF;
                rd_data_dirty_bit[w] = 1'b1;
            end
        end
        rd_data_evict_way = rd_pipe[RD_LAT-1] ? m_evict : 4'hE;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(logic hit, llc_way_t hw, logic ef, llc_way_t ew, llc_way_t ev,
                                llc_way_t cw, llc_tag_t ct, llc_state_t cs, line_t cl,
                                owner_t co, sharers_t csh, logic cd);
        exp_t e;
        e.cyc = 0; e.hit = hit; e.hw = hw; e.ef = ef; e.ew = ew; e.ev = ev;
        e.cw = cw; e.ctag = ct; e.cst = cs; e.cline = cl; e.cown = co; e.csh = csh; e.cdirty = cd;
        return e;
    endfunction

    // kind 1: all VALID tag 0x100+w, ways 3,7 VALID 0x1A, way 12 INVALID 0x1A, evict 6
    // kind 2: all VALID tag 0x200+w, evict 9
    // kind 3: all VALID tag 0x300+w except way 2 INVALID, evict 1
    // kind 4: way 0 VALID 0x55, others INVALID 0x55, evict 3
    // kind 5: all INVALID tag 0x1A, evict 7
    task automatic set_image(input llc_set_t s, input int kind);
        m_set = s;
        for (int w = 0; w < NW; w++) begin
            case (kind)
                1: begin
                    m_tag[w] = (w == 3 || w == 7 || w == 12) ? 16'h001A : 16'(16'h0100 + w);
                    m_state[w] = (w == 12) ? `INVALID : `VALID;
                end
                2: begin m_tag[w] = 16'(16'h0200 + w); m_state[w] = `VALID; end
                3: begin m_tag[w] = 16'(16'h0300 + w); m_state[w] = (w == 2) ? `INVALID : `VALID; end
                4: begin m_tag[w] = 16'h0055; m_state[w] = (w == 0) ? `VALID : `INVALID; end
                default: begin m_tag[w] = 16'h001A; m_state[w] = `INVALID; end
            endcase
        end
        case (kind)
            1: m_evict = 4'd6;
            2: m_evict = 4'd9;
            3: m_evict = 4'd1;
            4: m_evict = 4'd3;
            default: m_evict = 4'd7;
        endcase
    endtask

    // Presents a request (at a negedge) until accepted, then queues its expectation.
    task automatic do_req(input llc_set_t s, input llc_tag_t t, input int kind,
                          input exp_t e, output int acc_edge);
        int n;
        req_set = s; req_tag = t; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc_edge = -1;
        if (!req_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            set_image(s, kind);
            acc_edge = cyc + 1;
            e.cyc    = acc_edge + RD_LAT + 2;
            exp_q.push_back(e);
            accepts++;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bufs_valid || !req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n >= 300), 64'd0);
    endtask

    // Acknowledge after ack_delay held cycles.
    initial begin
        int held;
        held = 0;
        bufs_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bufs_ack) begin
                bufs_ack = 1'b0;
            end else if (bufs_valid) begin
                if (held >= ack_delay) begin
                    bufs_ack      = 1'b1;
                    last_ack_edge = cyc + 1;
                    held          = 0;
                end else begin
                    held++;
                end
            end else begin
                held = 0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t cur;
        logic have, prev_bv;
        have = 1'b0; prev_bv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_bv = 1'b0;
                have    = 1'b0;
            end else begin
                if (bufs_valid && !prev_bv) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_bufs_valid", 64'd1, 64'd0);
                        have = 1'b0;
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                        chk("latency_cycle", 64'(cyc), 64'(cur.cyc));
                    end
                end
                if (upd_q.size() != 0 && upd_q[0].cyc <= cyc) cur = upd_q.pop_front();
                if (bufs_valid && have) begin
                    chk("tag_hit", 64'(tag_hit), 64'(cur.hit));
                    chk("hit_way", 64'(hit_way), 64'(cur.hw));
                    chk("empty_way_found", 64'(empty_way_found), 64'(cur.ef));
                    chk("empty_way", 64'(empty_way), 64'(cur.ew));
                    chk("evict_way_buf", 64'(evict_way_buf), 64'(cur.ev));
                    chk("tags_buf", 64'(tags_buf[cur.cw]), 64'(cur.ctag));
                    chk("states_buf", 64'(states_buf[cur.cw]), 64'(cur.cst));
                    chk("lines_buf", lines_buf[cur.cw], cur.cline);
                    chk("owners_buf", 64'(owners_buf[cur.cw]), 64'(cur.cown));
                    chk("sharers_buf", 64'(sharers_buf[cur.cw]), 64'(cur.csh));
                    chk("dirty_bits_buf", 64'(dirty_bits_buf[cur.cw]), 64'(cur.cdirty));
                    chk("req_ready_in_hold", 64'(req_ready), 64'd0);
                    chk("rd_en_in_hold", 64'(rd_en), 64'd0);
                end
                prev_bv = bufs_valid;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, acc_b, p0, n;
        logic [63:0] orv;
        exp_t e_byp;
        rst = 1'b1; req_valid = 1'b0; req_set = '0; req_tag = '0;
        wr_en = 1'b0; wr_set = '0; wr_way = '0; wr_data_tag = '0; wr_data_state = '0;
        wr_data_hprot = 1'b0; wr_data_line = '0; wr_data_owner = '0; wr_data_sharers = '0;
        wr_data_dirty_bit = 1'b0; wr_data_evict_way = '0;
        set_image(8'h00, 5);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rd_en", 64'(rd_en), 64'd0);
        chk("reset_bufs_valid", 64'(bufs_valid), 64'd0);
        chk("reset_lookup", 64'({tag_hit, hit_way, empty_way_found, empty_way}), 64'd0);

        // two hits (3 and 7), INVALID way 12 with matching tag
        ack_delay = 2;
        do_req(8'h05, 16'h001A, 1, mk(1'b1, 4'd3, 1'b1, 4'd12, 4'd6, 4'd7, 16'h001A, `VALID,
               64'hC0DE_0000_0000_0507, 4'd7, 16'h0080, 1'b1), acc);
        wait_done();

        // reset in the middle of WAIT clears everything; no second rd_en
        req_set = 8'h11; req_tag = 16'h001A; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        accepts++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_req_ready", 64'(req_ready), 64'd1);
        chk("rst_wait_bufs_valid", 64'(bufs_valid), 64'd0);
        orv = 64'(evict_way_buf) | 64'(tag_hit) | 64'(hit_way) | 64'(empty_way) | 64'(empty_way_found);
        for (int w = 0; w < NW; w++) begin
            orv |= 64'(tags_buf[w]) | 64'(states_buf[w]) | 64'(hprots_buf[w]) | lines_buf[w] |
                   64'(owners_buf[w]) | 64'(sharers_buf[w]) | 64'(dirty_bits_buf[w]);
        end
        chk("rst_wait_bufs_zero", orv, 64'd0);
        p0 = rd_pulses;
        repeat (10) @(negedge clk);
        chk("rst_wait_no_repulse", 64'(rd_pulses), 64'(p0));
        chk("rst_wait_no_valid", 64'(bufs_valid), 64'd0);

        // all VALID, no match
        do_req(8'h21, 16'h001A, 2, mk(1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 4'd15, 16'h020F, `VALID,
               64'hC0DE_0000_0000_210F, 4'd15, 16'h8000, 1'b1), acc);
        wait_done();

        // way 2 INVALID, buffers held for 10+ cycles
        ack_delay = 10;
        do_req(8'h33, 16'h001A, 3, mk(1'b0, 4'd0, 1'b1, 4'd2, 4'd1, 4'd2, 16'h0302, `INVALID,
               64'hC0DE_0000_0000_3302, 4'd2, 16'h0004, 1'b0), acc);
        wait_done();

        // back-to-back: second request held, accepted the edge after ack
        ack_delay = 2;
        do_req(8'h40, 16'h0205, 2, mk(1'b1, 4'd5, 1'b0, 4'd0, 4'd9, 4'd5, 16'h0205, `VALID,
               64'hC0DE_0000_0000_4005, 4'd5, 16'h0020, 1'b1), acc);
        do_req(8'h09, 16'h0055, 4, mk(1'b1, 4'd0, 1'b1, 4'd1, 4'd3, 4'd0, 16'h0055, `VALID,
               64'hC0DE_0000_0000_0900, 4'd0, 16'h0001, 1'b0), acc_b);
        chk("b2b_accept_edge", 64'(acc_b), 64'(last_ack_edge + 1));
        wait_done();

        // same-set write during HOLD
        ack_delay = 8;
        do_req(8'h05, 16'h001A, 5, mk(1'b0, 4'd0, 1'b1, 4'd0, 4'd7, 4'd4, 16'h001A, `INVALID,
               64'hC0DE_0000_0000_0504, 4'd4, 16'h0010, 1'b0), acc);
        n = 0;
        while (!bufs_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bypass_wait_valid", 64'(bufs_valid), 64'd1);
        @(negedge clk);
        wr_en = 1'b1; wr_set = 8'h05; wr_way = 4'd4; wr_data_tag = 16'h001A;
        wr_data_state = `VALID; wr_data_hprot = 1'b1; wr_data_line = 64'hBEEF_BEEF_0000_0004;
        wr_data_owner = 4'd9; wr_data_sharers = 16'h0200; wr_data_dirty_bit = 1'b1;
        wr_data_evict_way = 4'd2;
`ifdef LLC_RD_BYPASS_EN
        e_byp = mk(1'b1, 4'd4, 1'b1, 4'd0, 4'd2, 4'd4, 16'h001A, `VALID,
                   64'hBEEF_BEEF_0000_0004, 4'd9, 16'h0200, 1'b1);
`else
        e_byp = mk(1'b0, 4'd0, 1'b1, 4'd0, 4'd7, 4'd4, 16'h001A, `INVALID,
                   64'hC0DE_0000_0000_0504, 4'd4, 16'h0010, 1'b0);
`endif
        e_byp.cyc = cyc + 1;
        upd_q.push_back(e_byp);
        @(negedge clk);
        wr_en = 1'b0;
        wait_done();

        chk("queue_drained", 64'(exp_q.size() + upd_q.size()), 64'd0);
        chk("rd_en_pulses", 64'(rd_pulses), 64'(accepts));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
